face_detect_stage_acc: RTL and testbench

//  Consumes the signed 64-bit weighted rectangle products from the face_detect_mul_32s_32s_64 pipeline.

---
 rtl/face_detect_stage_acc.sv | 125 ++++++++++++
 tb/tb_face_detect_stage_acc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/face_detect_stage_acc.sv
// Haar cascade stage accumulator: sums the rectangle products of each feature,
// picks the left or right leaf by comparing against the feature threshold,
// keeps a saturating stage sum and reports pass/fail at the end of the stage.
module face_detect_stage_acc #(
    parameter int PROD_WIDTH = 64,
    parameter int VAL_WIDTH  = 32,
    parameter int MAX_RECTS  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PROD_WIDTH-1:0] in_prod,
    input  logic                         in_last_rect,
    input  logic                         in_last_feat,
    input  logic signed [PROD_WIDTH-1:0] feat_thresh,
    input  logic signed [VAL_WIDTH-1:0]  feat_left,
    input  logic signed [VAL_WIDTH-1:0]  feat_right,
    input  logic signed [VAL_WIDTH-1:0]  stage_thresh,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_pass,
    output logic signed [VAL_WIDTH-1:0]  out_stage_sum,
    output logic                         err
);
    // Two guard bits cover the sum of up to MAX_RECTS (<= 4) full-width products.
    localparam int FW = PROD_WIDTH + 2;
    localparam int CW = $clog2(MAX_RECTS + 1);

    typedef enum logic [1:0] {ACC, CMP, DONE} state_t;

    state_t                       state, state_nxt;
    logic signed [FW-1:0]         feat_sum;
    logic [CW-1:0]                rect_cnt;
    logic signed [PROD_WIDTH-1:0] thr_q;
    logic signed [VAL_WIDTH-1:0]  left_q, right_q, stage_thresh_q, stage_sum;
    logic                         last_feat_q;

    logic                         accept, forced, closing;
    logic signed [FW-1:0]         prod_ext, thr_ext, feat_sum_nxt;
    logic signed [VAL_WIDTH-1:0]  leaf, sat_sum;
    logic signed [VAL_WIDTH:0]    wide_sum;

    // Handshake, feature close detection and the saturating leaf add.
    always_comb begin
        in_ready     = (state == ACC) && !reset;
        out_valid    = (state == DONE) && !reset;
        accept       = in_valid && in_ready && ce;
        // The beat that fills the last rectangle slot closes the feature even
        // without in_last_rect; that is a malformed feature and flags err.
        forced       = (rect_cnt == CW'(MAX_RECTS - 1)) && !in_last_rect;
        closing      = in_last_rect || forced;
        prod_ext     = {{2{in_prod[PROD_WIDTH-1]}}, in_prod};
        thr_ext      = {{2{thr_q[PROD_WIDTH-1]}}, thr_q};
        feat_sum_nxt = feat_sum + prod_ext;
        leaf         = (feat_sum < thr_ext) ? left_q : right_q;
        wide_sum     = {stage_sum[VAL_WIDTH-1], stage_sum} + {leaf[VAL_WIDTH-1], leaf};
        sat_sum      = wide_sum[VAL_WIDTH-1:0];
        if (wide_sum[VAL_WIDTH] != wide_sum[VAL_WIDTH-1])
            sat_sum = wide_sum[VAL_WIDTH] ? {1'b1, {(VAL_WIDTH-1){1'b0}}}
                                          : {1'b0, {(VAL_WIDTH-1){1'b1}}};
    end

    // Next-state logic: ACC collects beats, CMP is a one-cycle leaf update,
    // DONE holds the result until the controller takes it.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && closing) state_nxt = CMP;
            CMP:     if (ce) state_nxt = last_feat_q ? DONE : ACC;
            DONE:    if (ce && out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ACC;
        else       state <= state_nxt;
    end

    // Datapath registers; everything freezes while ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            feat_sum       <= '0;
            rect_cnt       <= '0;
            thr_q          <= '0;
            left_q         <= '0;
            right_q        <= '0;
            stage_thresh_q <= '0;
            stage_sum      <= '0;
            last_feat_q    <= 1'b0;
            out_pass       <= 1'b0;
            out_stage_sum  <= '0;
            err            <= 1'b0;
        end else if (ce) begin
            case (state)
                ACC: if (accept) begin
                    feat_sum <= feat_sum_nxt;
                    rect_cnt <= rect_cnt + CW'(1);
                    if (closing) begin
                        thr_q       <= feat_thresh;
                        left_q      <= feat_left;
                        right_q     <= feat_right;
                        last_feat_q <= in_last_rect && in_last_feat;
                        if (in_last_rect && in_last_feat) stage_thresh_q <= stage_thresh;
                        if (forced) err <= 1'b1;
                    end
                end
                CMP: begin
                    stage_sum <= sat_sum;
                    feat_sum  <= '0;
                    rect_cnt  <= '0;
                    if (last_feat_q) begin
                        out_pass      <= (sat_sum >= stage_thresh_q);
                        out_stage_sum <= sat_sum;
                    end
                end
                DONE: if (out_ready) stage_sum <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_face_detect_stage_acc.sv
// Self-checking bench for face_detect_stage_acc: a reference model pushes the
// expected stage result to a queue when the last beat is accepted; the result
// is popped and compared when the DUT raises out_valid.
module tb_face_detect_stage_acc;
    logic               clk = 1'b0;
    logic               reset, ce, in_valid, in_ready, in_last_rect, in_last_feat;
    logic signed [63:0] in_prod, feat_thresh;
    logic signed [31:0] feat_left, feat_right, stage_thresh, out_stage_sum;
    logic               out_valid, out_ready, out_pass, err;

    typedef struct {bit pass; logic [31:0] sum;} exp_t;
    exp_t   sb[$];
    int     checks = 0, failures = 0;
    longint m_feat = 0, m_stage = 0;
    int     m_cnt = 0;

    always #5 clk = ~clk;

    face_detect_stage_acc dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last_rect(in_last_rect), .in_last_feat(in_last_feat),
        .feat_thresh(feat_thresh), .feat_left(feat_left), .feat_right(feat_right),
        .stage_thresh(stage_thresh), .out_valid(out_valid), .out_ready(out_ready),
        .out_pass(out_pass), .out_stage_sum(out_stage_sum), .err(err)
    );

    // Drive one beat, wait (bounded) for acceptance, update the model.
    task automatic beat(input longint prod, input bit lr, input bit lf, input longint thr,
                        input int l, input int r, input int st);
        int n = 0;
        int leaf;
        longint s;
        @(negedge clk);
        in_prod = prod; in_last_rect = lr; in_last_feat = lf; feat_thresh = thr;
        feat_left = l; feat_right = r; stage_thresh = st; in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_feat += prod; m_cnt++;
        if (lr || m_cnt == 3) begin
            leaf = (m_feat < thr) ? l : r;
            s = m_stage + leaf;
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            m_stage = s; m_feat = 0; m_cnt = 0;
            if (lr && lf) begin
                sb.push_back('{pass: (m_stage >= st), sum: 32'(m_stage)});
                m_stage = 0;
            end
        end
    endtask

    // Wait for the result, pop the scoreboard, optionally hold off out_ready, then release.
    task automatic drain_result(input int lat, input int hold);
        int n = 0;
        exp_t e;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin
            failures++; $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
            return;
        end
        if (lat >= 0) begin
            checks++;
            if (n != lat) begin failures++; $display("FAIL result_latency got=%0d required=%0d", n, lat); end
        end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL scoreboard_empty unexpected result"); return; end
        e = sb.pop_front();
        checks++;
        if (out_pass !== e.pass) begin failures++; $display("FAIL out_pass got=%0b required=%0b", out_pass, e.pass); end
        checks++;
        if (out_stage_sum !== e.sum) begin failures++; $display("FAIL out_stage_sum got=%h required=%h", out_stage_sum, e.sum); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pass !== e.pass || out_stage_sum !== e.sum) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d valid=%0b ready=%0b pass=%0b sum=%h required 1 0 %0b %h",
                         i, out_valid, in_ready, out_pass, out_stage_sum, e.pass, e.sum);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL release valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_prod = '0; in_last_rect = 0; in_last_feat = 0; feat_thresh = '0;
        feat_left = '0; feat_right = '0; stage_thresh = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pass !== 1'b0 || out_stage_sum !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready=%0b valid=%0b pass=%0b sum=%h err=%0b required all 0",
                     in_ready, out_valid, out_pass, out_stage_sum, err);
        end
        reset = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b required=1", in_ready); end
    endtask

    task automatic test_single;
        beat(100, 0, 0, 0, 0, 0, 0);
        beat(-40, 1, 1, 50, 7, -3, -5);
        drain_result(1, 0);
    endtask

    task automatic test_two_feat;
        beat(10, 1, 0, 20, 4, -1, 0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL cmp_bubble got=%0b required=0", in_ready); end
        beat(30, 1, 1, 30, -8, 6, 11);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL cmp_bubble2 got=%0b required=0", in_ready); end
        drain_result(1, 0);
    endtask

    task automatic test_saturate;
        beat(0, 1, 0, 1, 32'h7FFFFFF0, 0, 0);
        beat(0, 1, 1, 1, 32'h00000100, 0, 0);
        drain_result(1, 0);
        beat(0, 1, 0, 1, 32'h80000010, 0, 0);
        beat(0, 1, 1, 1, -256, 0, 0);
        drain_result(1, 0);
    endtask

    task automatic test_back_to_back;
        beat(3, 1, 1, 2, 0, 9, 9);
        drain_result(1, 5);
        // Leftover stage_sum would corrupt this stage.
        beat(-1, 1, 1, 0, 5, 100, 5);
        drain_result(1, 0);
    endtask

    task automatic test_max_rects;
        beat(1, 0, 0, 0, 0, 0, 0);
        beat(2, 0, 0, 0, 0, 0, 0);
        beat(3, 0, 1, 10, 9, -9, 99);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL forced_close err=%0b ready=%0b required 1 0", err, in_ready);
        end
        beat(5, 1, 1, 0, 1, 2, 11);
        drain_result(1, 0);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b required=1", err); end
    endtask

    task automatic test_ce;
        beat(7, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ce = 1'b0; in_valid = 1'b1; in_prod = 1000; in_last_rect = 1'b1; in_last_feat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++; $display("FAIL ce_freeze_acc cyc=%0d ready=%0b valid=%0b required 1 0", i, in_ready, out_valid);
            end
        end
        @(negedge clk); ce = 1'b1; in_valid = 1'b0;
        beat(8, 1, 1, 15, 3, -2, -2);
        @(posedge clk); #1;
        @(negedge clk); ce = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL ce_freeze_done cyc=%0d valid=%0b required=1", i, out_valid); end
        end
        @(negedge clk); ce = 1'b1; out_ready = 1'b0;
        drain_result(-1, 0);
    endtask

    task automatic test_reset_mid;
        beat(50, 0, 0, 0, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_feat = 0; m_cnt = 0; m_stage = 0;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b required=0", err); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_abort cyc=%0d valid=%0b required=0", i, out_valid); end
        end
        beat(-5, 1, 1, -4, 12, 0, 12);
        drain_result(1, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_feat();
        test_saturate();
        test_back_to_back();
        test_max_rects();
        test_ce();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
